seq_serial_add4: RTL and testbench
==================================

# seq_serial_add4

Serial-input counterpart of the 2-stage four-input pipelined adder. Instead of four parallel 8-bit operands, it accepts operands one per handshake over a val/rdy stream. It groups them four at a time and presents the pairwise sums and the total on a val/rdy output. It sits where operands arrive from a narrow channel and must be reduced to the same out01/out23/out result triple as the parallel adder.

## Interface
- No parameters; data width fixed at 8 bits.
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- in_val  input  1  operand valid
- in_rdy  output  1  block can accept an operand this cycle
- in_  input  8  operand
- out_val  output  1  result triple valid
- out_rdy  input  1  consumer accepts result this cycle
- out01  output  8  operand0 + operand1 of current group, mod 256
- out23  output  8  operand2 + operand3 of current group, mod 256
- out  output  8  out01 + out23, mod 256

## Operation
- An input transfer occurs when in_val && in_rdy on a rising edge.
- An output transfer occurs when out_val && out_rdy on a rising edge.
- Registers:
  - acc01, acc23 (8 b each)
  - cnt (2 b): index of the next operand within the group
  - state ∈ {ACCUM, FULL}
- ACCUM (out_val=0, in_rdy=1). On input transfer:
  - cnt=0: acc01 ← in_
  - cnt=1: acc01 ← acc01 + in_
  - cnt=2: acc23 ← in_
  - cnt=3: acc23 ← acc23 + in_, state ← FULL
  - cnt ← cnt+1 (wraps 3→0)
- FULL (out_val=1):
  - out01 = acc01, out23 = acc23, out = acc01 + acc23, driven combinationally from registers.
  - in_rdy = out_rdy (pass-through ready).
  - Output transfer without input transfer: state ← ACCUM; cnt remains 0.
  - Simultaneous output and input transfer: state ← ACCUM, acc01 ← in_, cnt ← 1. The new group starts the same cycle the old result leaves.
  - in_val with out_rdy=0: no transfer; operand must be held by the producer.
- Arithmetic: all adds are 8-bit, carry discarded. Signed and unsigned results are identical bit patterns; 127+1 → 0x80 and 0x80+0x80 → 0x00.
- In ACCUM, out01/out23/out still reflect acc01/acc23 (partial values) but are don't-care because out_val=0. The bench checks them only when out_val=1.
- Gaps (in_val=0) in ACCUM hold all state; there is no timeout.

## Timing
- Reset (any cycle, including mid-group or in FULL): state ← ACCUM, cnt ← 0, acc01 ← 0, acc23 ← 0. Outputs the cycle after reset: out_val=0, in_rdy=1, out01=out23=out=0.
- Any partial group in flight at reset is discarded.
- Latency: out_val rises on the edge that accepts operand 3, so it is visible the cycle after the fourth input transfer.
- Throughput: with in_val and out_rdy held high, one result every 4 cycles, with no bubble between groups.
- Stalled output: result and out_val held stable until out_rdy; in_rdy stays 0 for the whole stall.
- No combinational path from in_val/in_ to outputs. out_rdy → in_rdy is the only combinational input-to-output path.

## Structure
- Shared package (adder_pkg): 8-bit operand typedef and state enum {ACCUM, FULL}.
- The 8-bit result datapath (acc01, acc23 and the final adder) goes in a sub-module, seq_serial_add4_dpath.
- Control (state, cnt, in_rdy/out_val, write enables) stays in the top module.
- Single flat block otherwise; no memories.

## Test plan
- Basic group: reset; operands 1,2,3,4 on consecutive cycles with out_rdy=1 → one cycle after operand 4, out_val=1 with out01=0x03, out23=0x07, out=0x0A.
- Overflow: operands 127,1,0x80,0xFF → out01=0x80, out23=0x7F, out=0xFF. Then 64,64,64,64 → out01=0x80, out23=0x80, out=0x00.
- Back-to-back: continuous in_val=1, out_rdy=1, groups (1,1,1,1) then (2,3,4,1) → out_val pulses every 4th cycle with out=0x04 then 0x0A. in_rdy never drops.
- Backpressure: complete group 10,20,30,40, hold out_rdy=0 for 3 cycles with in_val=1 → in_rdy=0 and out01=0x1E, out23=0x46, out=0x64 stable throughout. Raising out_rdy accepts the pending operand as cnt=0 of the next group in the same cycle.
- Gaps: operands 5,_,6,_,_,7,8 (_ = in_val low) → out01=0x0B, out23=0x0F, out=0x1A. Result appears only after the fourth valid operand.
- Reset mid-group: accept 9,9, assert reset 1 cycle, then send 1,2,3,4 → result out=0x0A with no residue from the 9s. Also, reset while in FULL → out_val=0 next cycle.

Source files
------------

// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types for the four-operand adder family.
//   operand_t : 8-bit operand / result word (signed and unsigned share bits)
//   state_e   : group-collection state of the serial adder
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int OPERAND_W = 8;

    typedef logic [OPERAND_W-1:0] operand_t;

    // ACCUM: collecting operands of a group.
    // FULL : a complete result waits for the consumer.
    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Modulo-256 add; the carry is intentionally dropped.
    function automatic operand_t add_wrap(input operand_t a, input operand_t b);
        return operand_t'(a + b);
    endfunction

endpackage

// File: rtl/seq_serial_add4_dpath.sv
// -----------------------------------------------------------------------------
// seq_serial_add4_dpath
// Result datapath of the serial four-input adder: the two pair accumulators
// and the final adder.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (clears accumulators)
//   in_            : operand being accepted this cycle
//   wr01, wr23     : write enable of acc01 / acc23
//   acc_add        : 1 = accumulator += in_, 0 = accumulator <= in_
//   out01, out23   : accumulator contents
//   out            : out01 + out23 (mod 256), purely combinational from flops
// -----------------------------------------------------------------------------
module seq_serial_add4_dpath
    import adder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_,
    input  logic       wr01,
    input  logic       wr23,
    input  logic       acc_add,
    output logic [7:0] out01,
    output logic [7:0] out23,
    output logic [7:0] out
);

    operand_t acc01_q, acc01_d;
    operand_t acc23_q, acc23_d;

    always_comb begin
        acc01_d = acc01_q;
        acc23_d = acc23_q;
        if (wr01) begin
            acc01_d = acc_add ? add_wrap(acc01_q, in_) : in_;
        end
        if (wr23) begin
            acc23_d = acc_add ? add_wrap(acc23_q, in_) : in_;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc01_q <= '0;
            acc23_q <= '0;
        end else begin
            acc01_q <= acc01_d;
            acc23_q <= acc23_d;
        end
    end

    assign out01 = acc01_q;
    assign out23 = acc23_q;
    assign out   = add_wrap(acc01_q, acc23_q);

endmodule

// File: rtl/seq_serial_add4.sv
// -----------------------------------------------------------------------------
// seq_serial_add4
// Serial-input four-operand adder. Operands arrive one per val/rdy handshake,
// are grouped four at a time, and the pairwise sums plus the total are offered
// on a val/rdy output.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   in_val/in_rdy/in_  : operand stream (8 bit)
//   out_val/out_rdy    : result handshake
//   out01              : operand0 + operand1 (mod 256)
//   out23              : operand2 + operand3 (mod 256)
//   out                : out01 + out23 (mod 256)
// -----------------------------------------------------------------------------
module seq_serial_add4
    import adder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [7:0] in_,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] out01,
    output logic [7:0] out23,
    output logic [7:0] out
);

    state_e     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic in_xfer;
    logic out_xfer;
    logic wr01;
    logic wr23;
    logic acc_add;

    assign out_val = (state_q == FULL);
    // While a result is pending, a new operand may enter only in the cycle the
    // result leaves, so ready is passed straight through from the consumer.
    assign in_rdy  = (state_q == ACCUM) || out_rdy;

    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr01    = 1'b0;
        wr23    = 1'b0;
        acc_add = 1'b0;
        case (state_q)
            ACCUM: begin
                if (in_xfer) begin
                    // cnt[1] selects the pair, cnt[0] selects load vs add.
                    wr01    = ~cnt_q[1];
                    wr23    =  cnt_q[1];
                    acc_add =  cnt_q[0];
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d = ACCUM;
                    cnt_d   = 2'd0;
                    // Overlapped transfer: operand 0 of the next group lands
                    // in the same cycle the old result is taken.
                    if (in_xfer) begin
                        wr01  = 1'b1;
                        cnt_d = 2'd1;
                    end
                end
            end
            default: begin
                state_d = ACCUM;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    seq_serial_add4_dpath u_dpath (
        .clk     (clk),
        .reset   (reset),
        .in_     (in_),
        .wr01    (wr01),
        .wr23    (wr23),
        .acc_add (acc_add),
        .out01   (out01),
        .out23   (out23),
        .out     (out)
    );

endmodule

// File: tb/tb_seq_serial_add4.sv
module tb_seq_serial_add4;

    logic       clk;
    logic       reset;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out01;
    logic [7:0] out23;
    logic [7:0] out;

    int checks   = 0;
    int failures = 0;

    // Reference model: operands of the group being collected and the
    // completed result waiting for the consumer.
    logic [7:0] ops[$];
    bit         grp_done;
    logic [7:0] res01, res23, res;

    // Last result triple actually handed over by the DUT.
    logic [7:0] lo01, lo23, lo;
    int         n_out;

    seq_serial_add4 dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .in_     (in_),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out01   (out01),
        .out23   (out23),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%02h exp=0x%02h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle against the model,
    // then advance the model by the transfers that the edge performs.
    task automatic cycle(input bit v, input logic [7:0] d, input bit ordy);
        bit exp_irdy;
        in_val  = v;
        in_     = d;
        out_rdy = ordy;
        @(negedge clk);
        exp_irdy = !grp_done || ordy;
        chk_val("out_val", {7'd0, out_val}, {7'd0, grp_done});
        chk_val("in_rdy", {7'd0, in_rdy}, {7'd0, exp_irdy});
        if (grp_done) begin
            chk_val("out01", out01, res01);
            chk_val("out23", out23, res23);
            chk_val("out", out, res);
        end
        if (out_val && ordy) begin
            lo01 = out01;
            lo23 = out23;
            lo   = out;
            n_out++;
        end
        if (grp_done && ordy) grp_done = 0;
        if (v && exp_irdy) begin
            ops.push_back(d);
            if (ops.size() == 4) begin
                res01 = ops[0] + ops[1];
                res23 = ops[2] + ops[3];
                res   = res01 + res23;
                grp_done = 1;
                ops.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        in_val = 1'b0;
        in_    = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ops.delete();
        grp_done = 0;
        chk_val("rst_out_val", {7'd0, out_val}, 8'd0);
        chk_val("rst_in_rdy", {7'd0, in_rdy}, 8'd1);
        chk_val("rst_out01", out01, 8'h00);
        chk_val("rst_out23", out23, 8'h00);
        chk_val("rst_out", out, 8'h00);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] e);
        cycle(1, a, 1);
        cycle(1, b, 1);
        cycle(1, c, 1);
        cycle(1, e, 1);
    endtask

    initial begin
        int n0;
        reset   = 1'b1;
        in_val  = 1'b0;
        in_     = 8'h00;
        out_rdy = 1'b0;
        grp_done = 0;
        n_out    = 0;
        lo01 = '0; lo23 = '0; lo = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Basic group
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        cycle(0, 8'h00, 1);
        chk_val("basic_out01", lo01, 8'h03);
        chk_val("basic_out23", lo23, 8'h07);
        chk_val("basic_out", lo, 8'h0A);

        // Overflow / wrap
        send4(8'd127, 8'd1, 8'h80, 8'hFF);
        cycle(0, 8'h00, 1);
        chk_val("ovf1_out01", lo01, 8'h80);
        chk_val("ovf1_out23", lo23, 8'h7F);
        chk_val("ovf1_out", lo, 8'hFF);
        send4(8'd64, 8'd64, 8'd64, 8'd64);
        cycle(0, 8'h00, 1);
        chk_val("ovf2_out01", lo01, 8'h80);
        chk_val("ovf2_out23", lo23, 8'h80);
        chk_val("ovf2_out", lo, 8'h00);

        // Back-to-back groups, no bubble
        n0 = n_out;
        send4(8'd1, 8'd1, 8'd1, 8'd1);
        send4(8'd2, 8'd3, 8'd4, 8'd1);
        chk_val("b2b_first_out", lo, 8'h04);
        cycle(0, 8'h00, 1);
        chk_val("b2b_second_out", lo, 8'h0A);
        chk_val("b2b_count", 8'(n_out - n0), 8'd2);

        // Backpressure: stall 3 cycles with a pending operand
        send4(8'd10, 8'd20, 8'd30, 8'd40);
        repeat (3) cycle(1, 8'd50, 0);
        cycle(1, 8'd50, 1);
        chk_val("bp_out01", lo01, 8'h1E);
        chk_val("bp_out23", lo23, 8'h46);
        chk_val("bp_out", lo, 8'h64);
        cycle(1, 8'd60, 1);
        cycle(1, 8'd70, 1);
        cycle(1, 8'd80, 1);
        cycle(0, 8'h00, 1);
        chk_val("bp_next_out", lo, 8'h04);  // 50+60+70+80 = 260 mod 256

        // Gaps between operands
        n0 = n_out;
        cycle(1, 8'd5, 1);
        cycle(0, 8'hAA, 1);
        cycle(1, 8'd6, 1);
        cycle(0, 8'hBB, 1);
        cycle(0, 8'hCC, 1);
        cycle(1, 8'd7, 1);
        chk_val("gap_early", 8'(n_out - n0), 8'd0);
        cycle(1, 8'd8, 1);
        cycle(0, 8'h00, 1);
        chk_val("gap_out01", lo01, 8'h0B);
        chk_val("gap_out23", lo23, 8'h0F);
        chk_val("gap_out", lo, 8'h1A);

        // Reset mid-group discards the partial group
        cycle(1, 8'd9, 1);
        cycle(1, 8'd9, 1);
        do_reset();
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        cycle(0, 8'h00, 1);
        chk_val("rstmid_out", lo, 8'h0A);

        // Reset while a result is pending
        send4(8'd1, 8'd2, 8'd3, 8'd4);
        cycle(0, 8'h00, 0);
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 2; i++) cycle(0, 8'h00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
